// File: rtl/log.sv
// Frame logger: counts received frames and checks that their embedded 24-bit
// sequence numbers arrive in order, stopping after a run of idle cycles.
module log #(
  parameter int unsigned IDLE_TIMEOUT = 1000,
  parameter int unsigned SEQ_IDX      = 3
) (
  input  logic        clk125MHz,
  input  logic        rst,
  input  logic        rx_en,
  input  logic [7:0]  rx_data,
  output logic [31:0] countp,
  output logic [31:0] okp,
  output logic        finished,
  output logic        started
);

  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [7:0]  SEQ_HI  = 8'(SEQ_IDX);
  localparam logic [7:0]  SEQ_MID = 8'(SEQ_IDX + 1);
  localparam logic [7:0]  SEQ_LO  = 8'(SEQ_IDX + 2);

  logic              rx_en_q;
  logic              seen_low;
  logic              in_frame;
  logic [7:0]        byte_idx;
  logic [23:0]       seq;
  logic [23:0]       expected;
  logic              first;
  logic [IDLE_W-1:0] idle_cnt;

  logic              frame_start_c;
  logic              frame_end_c;
  logic              frame_valid_c;
  logic              seq_ok_c;
  logic              receiving_c;
  logic [7:0]        cur_idx_c;
  logic [IDLE_W-1:0] idle_next_c;

  // A start edge only counts once rx_en has been seen low since reset, so a
  // frame straddling the reset release is never treated as a new frame.
  always_comb begin
    frame_start_c = rx_en & ~rx_en_q & seen_low;
    receiving_c   = rx_en & (frame_start_c | in_frame);
    cur_idx_c     = 8'd0;
    if (!frame_start_c) begin
      cur_idx_c = (byte_idx == 8'hFF) ? 8'hFF : byte_idx + 8'd1;
    end
    frame_end_c   = ~rx_en & rx_en_q & in_frame;
    frame_valid_c = frame_end_c & (byte_idx >= SEQ_LO) & ~finished;
    seq_ok_c      = first | (seq == expected);
    idle_next_c   = idle_cnt + IDLE_W'(1);
  end

  always_ff @(posedge clk125MHz) begin
    if (rst) begin
      rx_en_q  <= 1'b0;
      seen_low <= 1'b0;
      in_frame <= 1'b0;
      byte_idx <= 8'd0;
      seq      <= 24'd0;
      expected <= 24'd0;
      first    <= 1'b1;
      idle_cnt <= '0;
      countp   <= 32'd0;
      okp      <= 32'd0;
      finished <= 1'b0;
      started  <= 1'b0;
    end else begin
      rx_en_q <= rx_en;
      if (!rx_en) seen_low <= 1'b1;
      if (rx_en) started <= 1'b1;

      // Byte index and sequence capture; a frame end always rewinds the index.
      if (receiving_c) begin
        in_frame <= 1'b1;
        byte_idx <= cur_idx_c;
        if (cur_idx_c == SEQ_HI)  seq[23:16] <= rx_data;
        if (cur_idx_c == SEQ_MID) seq[15:8]  <= rx_data;
        if (cur_idx_c == SEQ_LO)  seq[7:0]   <= rx_data;
      end else if (!rx_en) begin
        in_frame <= 1'b0;
        byte_idx <= 8'd0;
      end

      // finished is read before update, so a frame ending as it sets still counts.
      if (frame_valid_c) begin
        countp   <= countp + 32'd1;
        if (seq_ok_c) okp <= okp + 32'd1;
        expected <= seq + 24'd1;
        first    <= 1'b0;
      end

      if (rx_en) begin
        idle_cnt <= '0;
      end else if (started && !finished) begin
        idle_cnt <= idle_next_c;
        if (idle_next_c == IDLE_W'(IDLE_TIMEOUT)) finished <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_log.sv
// Scoreboard bench for log: frame stimulus queues expected counter values,
// a monitor compares them whenever countp moves.
module tb_log;

  localparam int unsigned SEQ_IDX = 3;
  localparam int unsigned IDLE_T  = 100;

  logic        clk;
  logic        rst;
  logic        rx_en;
  logic [7:0]  rx_data;
  logic [31:0] countp;
  logic [31:0] okp;
  logic        finished;
  logic        started;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] exp_count;
  logic [31:0] exp_ok;
  logic [63:0] sb_q[$];

  log #(.IDLE_TIMEOUT(IDLE_T), .SEQ_IDX(SEQ_IDX)) dut (
    .clk125MHz(clk),
    .rst(rst),
    .rx_en(rx_en),
    .rx_data(rx_data),
    .countp(countp),
    .okp(okp),
    .finished(finished),
    .started(started)
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: each countp change must match the oldest queued expectation.
  initial begin
    logic [31:0] prev;
    logic [63:0] e;
    prev = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev = countp;
      end else if (countp !== prev) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_count: got countp=%0d okp=%0d with nothing expected", countp, okp);
        end else begin
          e = sb_q.pop_front();
          check("sb_countp", countp, e[63:32]);
          check("sb_okp", okp, e[31:0]);
        end
        prev = countp;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 32'd0;
    exp_ok    = 32'd0;
  endtask

  // One frame of len bytes carrying seq at SEQ_IDX, then 5 idle cycles.
  task automatic send(input logic [23:0] seq, input int len, input bit counts, input bit in_order);
    if (counts) begin
      exp_count = exp_count + 32'd1;
      if (in_order) exp_ok = exp_ok + 32'd1;
      sb_q.push_back({exp_count, exp_ok});
    end
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      rx_en = 1'b1;
      if (i == SEQ_IDX)          rx_data = seq[23:16];
      else if (i == SEQ_IDX + 1) rx_data = seq[15:8];
      else if (i == SEQ_IDX + 2) rx_data = seq[7:0];
      else                       rx_data = 8'(i);
    end
    @(negedge clk);
    rx_en   = 1'b0;
    rx_data = 8'd0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int waited;
    rst       = 1'b1;
    rx_en     = 1'b0;
    rx_data   = 8'd0;
    exp_count = 32'd0;
    exp_ok    = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_countp", countp, 32'd0);
    check("reset_okp", okp, 32'd0);
    check("reset_finished", 32'(finished), 32'd0);
    check("reset_started", 32'(started), 32'd0);

    // Too-short frame: only started changes.
    send(24'h0, 5, 1'b0, 1'b0);
    check("short_countp", countp, 32'd0);
    check("short_okp", okp, 32'd0);
    check("short_started", 32'(started), 32'd1);

    // 5 first, 6 ok, 9 bad, 10 ok via resync.
    send(24'd5, 30, 1'b1, 1'b1);
    send(24'd6, 30, 1'b1, 1'b1);
    send(24'd9, 30, 1'b1, 1'b0);
    send(24'd10, 30, 1'b1, 1'b1);
    check("resync_countp", countp, 32'd4);
    check("resync_okp", okp, 32'd3);
    check("resync_finished", 32'(finished), 32'd0);

    // 24-bit wrap of the expected value.
    do_reset();
    send(24'hFFFFFF, 30, 1'b1, 1'b1);
    send(24'h000000, 30, 1'b1, 1'b1);
    check("wrap_countp", countp, 32'd2);
    check("wrap_okp", okp, 32'd2);

    // 80 frames: seq j for j<40, then stuck at 30.
    do_reset();
    for (int j = 0; j < 80; j++) begin
      send(24'((j < 40) ? j : 30), 30, 1'b1, j < 40);
    end
    check("run_finished_early", 32'(finished), 32'd0);
    waited = 0;
    while (!finished && waited < IDLE_T + 50) begin
      @(negedge clk);
      waited++;
    end
    check("run_finished", 32'(finished), 32'd1);
    check("run_started", 32'(started), 32'd1);
    check("run_countp", countp, 32'd80);
    check("run_okp", okp, 32'd40);

    // Frozen after finished.
    send(24'd40, 30, 1'b0, 1'b0);
    send(24'd41, 30, 1'b0, 1'b0);
    send(24'd42, 30, 1'b0, 1'b0);
    check("frozen_countp", countp, 32'd80);
    check("frozen_okp", okp, 32'd40);
    do_reset();
    check("rst2_countp", countp, 32'd0);
    check("rst2_okp", okp, 32'd0);
    check("rst2_finished", 32'(finished), 32'd0);
    check("rst2_started", 32'(started), 32'd0);

    // Reset mid-frame with rx_en held high: the frame is discarded.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rx_en   = 1'b1;
      rx_data = 8'(i);
      rst     = (i == 10);
    end
    @(negedge clk);
    rst   = 1'b0;
    rx_en = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_countp", countp, 32'd0);
    send(24'd7, 30, 1'b1, 1'b1);
    check("midrst_next_countp", countp, 32'd1);
    check("midrst_next_okp", okp, 32'd1);

    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/log.md
LOG -- requirements
Module: log

Interface
REQ-001 Parameter IDLE_TIMEOUT, default 1000, number of consecutive clk125MHz cycles with rx_en low, after started is set, that ends the logging run.
REQ-002 Parameter SEQ_IDX, default 3, byte index of the most-significant byte of the 24-bit sequence number; bytes SEQ_IDX, SEQ_IDX+1 and SEQ_IDX+2 form the number, MSB first.
REQ-003 clk125MHz  input  1  sole clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rx_en  input  1  receive-data-valid; high for the whole frame, one byte per cycle.
REQ-006 rx_data  input  8  receive byte, sampled when rx_en=1.
REQ-007 countp  output  32  number of valid frames received.
REQ-008 okp  output  32  number of valid frames whose sequence number is in order.
REQ-009 finished  output  1  sticky; logging run ended.
REQ-010 started  output  1  sticky; at least one frame has begun since reset.

Function
REQ-011 Byte index: 0 on the first cycle of a frame (rx_en=1 with previous rx_en=0), then +1 each cycle while rx_en=1; saturates at 255.
REQ-012 Sequence capture: byte at index SEQ_IDX loads seq[23:16], SEQ_IDX+1 loads seq[15:8], SEQ_IDX+2 loads seq[7:0].
REQ-013 Frame end: the first cycle with rx_en=0 after rx_en=1 (falling edge detected on registered rx_en).
REQ-014 Valid frame: frame end reached with byte index >= SEQ_IDX+2, i.e. all three sequence bytes captured; shorter frames are ignored entirely and change no state.
REQ-015 On a valid frame end, countp increments by 1, taking effect on the cycle after the frame-end cycle (one-cycle latency).
REQ-016 The first valid frame after reset is always in order: okp increments and the expected value is set to seq+1.
REQ-017 Later valid frames: if seq equals expected, okp increments; in every case expected is set to seq+1.
REQ-018 Resync rule: an out-of-order frame does not increment okp, but the next frame is judged against its seq+1.
REQ-019 Sequence arithmetic is 24-bit modulo: expected after 0xFFFFFF is 0x000000.
REQ-020 countp and okp wrap modulo 2^32; okp <= countp at all times.
REQ-021 started is set on the first cycle rx_en=1 after reset and stays 1 until reset.
REQ-022 Idle counter: counts consecutive rx_en=0 cycles while started=1 and finished=0; clears whenever rx_en=1.
REQ-023 finished is set when the idle counter reaches IDLE_TIMEOUT and stays 1 until reset.
REQ-024 A frame ending on the same cycle finished sets is still counted.
REQ-025 Once finished=1, countp, okp and the expected value are frozen; later frames are ignored.
REQ-026 A frame cut short by rx_en falling before index SEQ_IDX+2 resets the byte index; the next frame starts again at index 0.

Reset
REQ-027 While rst=1 at a clock edge: countp=0, okp=0, finished=0, started=0, byte index=0, idle counter=0, the first-frame flag is set, expected=0, and the registered rx_en=0.
REQ-028 rst takes priority over all inputs; a frame in progress when rst is asserted is discarded, and a frame whose rx_en stays high across the rst release is not counted, since it has no start edge after reset.
REQ-029 When rst is released, all outputs hold their reset values until the next qualifying event.

Verification
REQ-030 80 frames of 30 bytes with 5 idle cycles between them; bytes 3 and 4 = 0x00; byte 5 = j for j<40, else 30 -> final countp=80, okp=40, started=1, finished=1 after IDLE_TIMEOUT idle cycles.
REQ-031 A single frame of 5 bytes (too short) -> countp=0, okp=0, started=1.
REQ-032 Sequence numbers 5, 6, 9, 10 -> countp=4, okp=3 (5 first, 6 ok, 9 bad, 10 ok via resync).
REQ-033 Sequence numbers 0xFFFFFF then 0x000000 -> okp=2.
REQ-034 After finished=1, send 3 more valid frames -> countp and okp unchanged; then assert rst for 1 cycle -> all outputs 0.
REQ-035 Assert rst at byte 10 of a frame, holding rx_en high through the end of the frame -> countp=0 afterwards, and the next full frame counts as first, giving okp=1.
